// File: rtl/mem_seq_ctrl_if.sv
// mem_seq_ctrl_if
// CPU-side handshake bundle between the control unit (MAR/MDR) and the
// memory sequencer.
//   MOV      request, held high until MOC is seen
//   RW       1 = read, 0 = write
//   typeData 00 byte, 01 halfword, 10 word, 11 reserved
//   addr     byte address (MAR)
//   din      write data (MDR), low 8/16/32 bits used
//   dout     zero-extended read result
//   MOC      operation complete
//   ERR      misaligned/reserved access, valid while MOC=1
// modport master: CPU side; modport slave: sequencer side.
interface mem_seq_ctrl_if;
    logic        MOV;
    logic        RW;
    logic [1:0]  typeData;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        MOC;
    logic        ERR;

    modport master (
        output MOV, RW, typeData, addr, din,
        input  dout, MOC, ERR
    );

    modport slave (
        input  MOV, RW, typeData, addr, din,
        output dout, MOC, ERR
    );
endinterface

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl
// Performs one byte/halfword/word transfer per MOV/MOC handshake as a run of
// big-endian byte accesses to a byte-wide memory array. Reads are assembled
// into a zero-extended 32-bit result. Alignment checking and per-byte access
// timing (LAT cycles per byte) live here.
// Ports:
//   CLK, CLR     clock, synchronous active-high reset
//   cpu          CPU handshake (mem_seq_ctrl_if.slave)
//   mem_addr     byte address to the array (0 outside ACCESS)
//   mem_wdata    byte to write
//   mem_rdata    byte read, combinational from mem_addr
//   mem_we       write strobe, high in the last LAT cycle of each write byte
//   mem_re       read enable, high throughout a read access
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for MOV; latches the request when it is seen
// ACCESS | stepping through bytes k = 0..n-1, LAT cycles per byte
// DONE   | MOC high, dout/ERR held; leaves when MOV is sampled low
module mem_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LAT    = 1
) (
    input  logic              CLK,
    input  logic              CLR,
    mem_seq_ctrl_if.slave     cpu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic              mem_re
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam int                WAIT_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LAT - 1);

    state_t              state_q, state_d;
    logic                rw_q;
    logic [1:0]          type_q;
    logic [ADDR_W-1:0]   base_q;
    logic [31:0]         din_q;
    logic [1:0]          k_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [31:0]         asm_q;
    logic [31:0]         dout_q;
    logic                err_q;

    logic                req_bad;
    logic [1:0]          last_k;
    logic [1:0]          shift;
    logic [4:0]          lane_shamt;
    logic                byte_end;
    logic                last_byte;
    logic [31:0]         asm_next;
    logic [31:0]         unused_addr;

    // Only the low ADDR_W address bits reach the array.
    assign unused_addr = cpu.addr;

    assign req_bad = (cpu.typeData == 2'b11)
                   | ((cpu.typeData == 2'b01) & cpu.addr[0])
                   | ((cpu.typeData == 2'b10) & (cpu.addr[1:0] != 2'b00));

    always_comb begin
        case (type_q)
            2'b00:   last_k = 2'd0;
            2'b01:   last_k = 2'd1;
            default: last_k = 2'd3;
        endcase
    end

    // Byte k is the k-th most significant byte of the n-byte operand, so its
    // lane within the 32-bit value is (n-1-k).
    assign shift      = last_k - k_q;
    assign lane_shamt = {shift, 3'b000};
    assign byte_end   = (wait_q == '0);
    assign last_byte  = (k_q == last_k);
    assign asm_next   = asm_q | ({24'b0, mem_rdata} << lane_shamt);

    // Memory-side outputs depend on registered state only.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = 8'(din_q >> lane_shamt);
        if (state_q == S_ACCESS) begin
            mem_addr = base_q + ADDR_W'(k_q);
            mem_re   = rw_q;
            mem_we   = ~rw_q & byte_end;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu.MOV) begin
                    state_d = req_bad ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (byte_end && last_byte) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!cpu.MOV) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            rw_q   <= 1'b0;
            type_q <= 2'b00;
            base_q <= '0;
            din_q  <= '0;
            k_q    <= 2'd0;
            wait_q <= '0;
            asm_q  <= '0;
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu.MOV) begin
                        rw_q   <= cpu.RW;
                        type_q <= cpu.typeData;
                        base_q <= cpu.addr[ADDR_W-1:0];
                        din_q  <= cpu.din;
                        k_q    <= 2'd0;
                        wait_q <= WAIT_LOAD;
                        asm_q  <= '0;
                        err_q  <= req_bad;
                    end
                end
                S_ACCESS: begin
                    if (byte_end) begin
                        if (rw_q) begin
                            asm_q <= asm_next;
                        end
                        if (last_byte) begin
                            if (rw_q) begin
                                dout_q <= asm_next;
                            end
                        end else begin
                            k_q    <= k_q + 2'd1;
                            wait_q <= WAIT_LOAD;
                        end
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (!cpu.MOV) begin
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu.MOC  = (state_q == S_DONE);
    assign cpu.ERR  = err_q;
    assign cpu.dout = dout_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl
// Directed bench for mem_seq_ctrl: one instance with LAT=1, one with LAT=3,
// each attached to a byte-wide 256-entry memory model. Expected completions
// are queued when a request is driven and checked when MOC rises.
module tb_mem_seq_ctrl;

    typedef struct {
        logic [31:0] dout;
        logic        err;
        int          lat;
        int          nwe;
    } exp_t;

    logic clk = 1'b0;
    logic CLR = 1'b1;
    always #5 clk = ~clk;

    mem_seq_ctrl_if if1();
    mem_seq_ctrl_if if3();

    logic [7:0] addr1, wd1, rd1, addr3, wd3, rd3;
    logic       we1, re1, we3, re3;

    mem_seq_ctrl #(.ADDR_W(8), .LAT(1)) u1 (
        .CLK(clk), .CLR(CLR), .cpu(if1),
        .mem_addr(addr1), .mem_wdata(wd1), .mem_rdata(rd1),
        .mem_we(we1), .mem_re(re1)
    );

    mem_seq_ctrl #(.ADDR_W(8), .LAT(3)) u3 (
        .CLK(clk), .CLR(CLR), .cpu(if3),
        .mem_addr(addr3), .mem_wdata(wd3), .mem_rdata(rd3),
        .mem_we(we3), .mem_re(re3)
    );

    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic       mem_init = 1'b1;
    logic       pre_we   = 1'b0;
    logic       pre_sel  = 1'b0;
    logic [7:0] pre_addr = 8'h00;
    logic [7:0] pre_data = 8'h00;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 8'(i) ^ 8'hA5;
        end else if (pre_we && !pre_sel) begin
            mem1[pre_addr] <= pre_data;
        end else if (we1) begin
            mem1[addr1] <= wd1;
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int j = 0; j < 256; j++) mem3[j] <= 8'(j) ^ 8'hA5;
        end else if (pre_we && pre_sel) begin
            mem3[pre_addr] <= pre_data;
        end else if (we3) begin
            mem3[addr3] <= wd3;
        end
    end

    assign rd1 = mem1[addr1];
    assign rd3 = mem3[addr3];

    logic        sel = 1'b0;
    logic        moc_s, err_s, we_s, re_s;
    logic [31:0] dout_s;
    logic [7:0]  addr_s;
    assign moc_s  = sel ? if3.MOC  : if1.MOC;
    assign err_s  = sel ? if3.ERR  : if1.ERR;
    assign dout_s = sel ? if3.dout : if1.dout;
    assign we_s   = sel ? we3 : we1;
    assign re_s   = sel ? re3 : re1;
    assign addr_s = sel ? addr3 : addr1;

    int         checks   = 0;
    int         failures = 0;
    exp_t       sb[$];
    logic [7:0] addr_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic s, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_sel  = s;
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic set_mov(input logic s, input logic v);
        if (s) if3.MOV = v;
        else   if1.MOV = v;
    endtask

    task automatic xfer(input string tag, input logic s, input logic rw,
                        input logic [1:0] ty, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee, input int el,
                        input int enwe, input int hold);
        exp_t e;
        int   lat;
        int   nwe;
        logic got;
        e.dout = ed; e.err = ee; e.lat = el; e.nwe = enwe;
        sb.push_back(e);
        addr_q.delete();
        @(negedge clk);
        sel = s;
        if (s) begin
            if3.RW = rw; if3.typeData = ty; if3.addr = a; if3.din = d;
        end else begin
            if1.RW = rw; if1.typeData = ty; if1.addr = a; if1.din = d;
        end
        set_mov(s, 1'b1);
        lat = 0; nwe = 0; got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (moc_s) got = 1'b1;
            else begin
                if (we_s) nwe++;
                if (re_s || we_s) addr_q.push_back(addr_s);
            end
        end
        check({tag, "_moc_seen"}, 32'(got), 32'd1);
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_dout"}, dout_s, e.dout);
        check({tag, "_err"}, 32'(err_s), 32'(e.err));
        check({tag, "_we_cycles"}, 32'(nwe), 32'(e.nwe));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_moc"}, 32'(moc_s), 32'd1);
            check({tag, "_hold_dout"}, dout_s, e.dout);
            check({tag, "_hold_idle_bus"}, {30'd0, we_s, re_s}, 32'd0);
        end
        set_mov(s, 1'b0);
        @(negedge clk);
        check({tag, "_moc_fall"}, 32'(moc_s), 32'd0);
        check({tag, "_err_clear"}, 32'(err_s), 32'd0);
        check({tag, "_idle_addr"}, 32'(addr_s), 32'd0);
    endtask

    initial begin
        int          nwe;
        logic [31:0] last_dout;
        if1.MOV = 1'b0; if1.RW = 1'b0; if1.typeData = 2'b00; if1.addr = '0; if1.din = '0;
        if3.MOV = 1'b0; if3.RW = 1'b0; if3.typeData = 2'b00; if3.addr = '0; if3.din = '0;

        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        CLR      = 1'b0;
        check("rst_moc", 32'(if1.MOC), 32'd0);
        check("rst_err", 32'(if1.ERR), 32'd0);
        check("rst_dout", if1.dout, 32'd0);
        check("rst_bus", {22'd0, addr1, we1, re1}, 32'd0);
        check("rst_dout_lat3", if3.dout, 32'd0);

        preload(1'b0, 8'h10, 8'hDE);
        preload(1'b0, 8'h11, 8'hAD);
        preload(1'b0, 8'h12, 8'hBE);
        preload(1'b0, 8'h13, 8'hEF);
        preload(1'b1, 8'h05, 8'h80);

        // word read with MOV held 3 cycles past MOC
        xfer("rd_word", 1'b0, 1'b1, 2'b10, 32'h0000_0010, 32'h0,
             32'hDEAD_BEEF, 1'b0, 5, 0, 3);
        check("rd_word_naddr", 32'(addr_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++)
            check("rd_word_addr_seq", 32'(addr_q[i]), 32'h10 + 32'(i));

        xfer("wr_half", 1'b0, 1'b0, 2'b01, 32'h0000_0022, 32'h1234_ABCD,
             32'hDEAD_BEEF, 1'b0, 3, 2, 0);
        check("wr_half_m22", 32'(mem1[8'h22]), 32'hAB);
        check("wr_half_m23", 32'(mem1[8'h23]), 32'hCD);
        check("wr_half_m21", 32'(mem1[8'h21]), 32'(8'h21 ^ 8'hA5));
        check("wr_half_m24", 32'(mem1[8'h24]), 32'(8'h24 ^ 8'hA5));

        xfer("rd_byte_lat3", 1'b1, 1'b1, 2'b00, 32'h0000_0005, 32'h0,
             32'h0000_0080, 1'b0, 4, 0, 0);

        xfer("err_word_mis", 1'b0, 1'b1, 2'b10, 32'h0000_0002, 32'h0,
             32'hDEAD_BEEF, 1'b1, 1, 0, 0);
        xfer("err_reserved", 1'b0, 1'b0, 2'b11, 32'h0000_0000, 32'hFFFF_FFFF,
             32'hDEAD_BEEF, 1'b1, 1, 0, 0);
        xfer("err_half_mis", 1'b0, 1'b0, 2'b01, 32'h0000_0021, 32'h0000_5555,
             32'hDEAD_BEEF, 1'b1, 1, 0, 0);
        check("err_m21_kept", 32'(mem1[8'h21]), 32'(8'h21 ^ 8'hA5));

        xfer("rd_half", 1'b0, 1'b1, 2'b01, 32'hFFFF_FF22, 32'h0,
             32'h0000_ABCD, 1'b0, 3, 0, 0);

        // word write interrupted by reset on the edge that commits byte 1
        @(negedge clk);
        sel = 1'b0;
        if1.RW = 1'b0; if1.typeData = 2'b10; if1.addr = 32'h40; if1.din = 32'h1122_3344;
        if1.MOV = 1'b1;
        nwe = 0;
        for (int i = 0; i < 20 && nwe < 2; i++) begin
            @(negedge clk);
            if (we1) nwe++;
        end
        check("rstw_strobes", 32'(nwe), 32'd2);
        CLR     = 1'b1;
        if1.MOV = 1'b0;
        @(negedge clk);
        CLR = 1'b0;
        check("rstw_moc", 32'(if1.MOC), 32'd0);
        check("rstw_err", 32'(if1.ERR), 32'd0);
        check("rstw_dout", if1.dout, 32'd0);
        check("rstw_bus", {22'd0, addr1, we1, re1}, 32'd0);
        @(negedge clk);
        check("rstw_m40", 32'(mem1[8'h40]), 32'h11);
        check("rstw_m41", 32'(mem1[8'h41]), 32'h22);
        check("rstw_m42", 32'(mem1[8'h42]), 32'(8'h42 ^ 8'hA5));
        check("rstw_m43", 32'(mem1[8'h43]), 32'(8'h43 ^ 8'hA5));

        xfer("post_rst_rd", 1'b0, 1'b1, 2'b00, 32'h0000_0041, 32'h0,
             32'h0000_0022, 1'b0, 2, 0, 0);
        last_dout = 32'h0000_0022;
        xfer("post_rst_wr", 1'b0, 1'b0, 2'b00, 32'h0000_0043, 32'h0000_007E,
             last_dout, 1'b0, 2, 1, 0);
        check("post_rst_m43", 32'(mem1[8'h43]), 32'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
